// File: rtl/mos6502_cycle_sequencer.sv
// 6502 instruction-cycle sequencer: produces T0, T1/SYNC and TRES2, and tracks
// T2..T5 extra cycles with a runaway-instruction timeout.
module mos6502_cycle_sequencer #(
  parameter int RST_CYCLES = 2,
  parameter int MAX_EXTRA  = 4
) (
  input  logic       CLK,
  input  logic       n_RES,
  input  logic       n_ready,
  input  logic       WR,
  input  logic       ENDS,
  input  logic       ENDX,
  output logic       T0,
  output logic       T1,
  output logic       SYNC,
  output logic       TRES2,
  output logic [2:0] T_EXT,
  output logic       TO_ERR
);

  // state | meaning
  // S_RST | post-reset startup, counting RST_CYCLES before the first T0
  // S_T0  | last cycle of the previous instruction
  // S_T1  | opcode fetch (SYNC)
  // S_TX  | extra cycle T2+, index in r_ext_cnt
  typedef enum logic [1:0] {S_RST, S_T0, S_T1, S_TX} state_t;

  localparam logic [2:0] RST_LAST = 3'(RST_CYCLES - 1);
  localparam logic [2:0] EXT_LAST = 3'(MAX_EXTRA - 1);

  state_t     r_state;
  logic [2:0] r_rst_cnt;
  logic [2:0] r_ext_cnt;
  logic       r_to_err;
  logic       w_step;

  // Write cycles cannot be stretched by RDY on the 6502.
  assign w_step = ~n_ready | WR;

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      r_state   <= S_RST;
      r_rst_cnt <= 3'd0;
      r_ext_cnt <= 3'd0;
      r_to_err  <= 1'b0;
    end else begin
      case (r_state)
        S_RST: begin
          r_rst_cnt <= r_rst_cnt + 3'd1;
          if (r_rst_cnt == RST_LAST) r_state <= S_T0;
        end
        S_T0: begin
          if (w_step) r_state <= S_T1;
        end
        S_T1: begin
          if (w_step) begin
            if (ENDS) begin
              r_state <= S_T0;
            end else begin
              r_state   <= S_TX;
              r_ext_cnt <= 3'd0;
            end
          end
        end
        S_TX: begin
          if (w_step) begin
            if (ENDX) begin
              r_state   <= S_T0;
              r_ext_cnt <= 3'd0;
            end else if (r_ext_cnt == EXT_LAST) begin
              r_state   <= S_T0;
              r_ext_cnt <= 3'd0;
              r_to_err  <= 1'b1;
            end else begin
              r_ext_cnt <= r_ext_cnt + 3'd1;
            end
          end
        end
        default: r_state <= S_RST;
      endcase
    end
  end

  assign T0     = (r_state == S_T0);
  assign T1     = (r_state == S_T1);
  assign SYNC   = (r_state == S_T1);
  assign TRES2  = (r_state == S_RST) || (r_state == S_T0);
  assign T_EXT  = (r_state == S_TX) ? r_ext_cnt : 3'd0;
  assign TO_ERR = r_to_err;

endmodule
